alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Sequential front-end that shares the single combinational `alu` between two requesters: the execute stage (port 0) and the branch/address unit (port 1). It arbitrates round-robin, latches the winning operation into registers that drive the ALU control and operand inputs, and captures the ALU result and flags. It returns them to the winner with a tagged one-cycle response pulse. It sits between the decode/execute logic and the `alu` instance, replacing the direct wiring.

## Interface
Parameters:
- `XLEN`, 32, operand and result width; must match `alu`.

Ports (`*` = 0, 1):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req*_valid`  in  1  request valid.
- `req*_ready`  out  1  request accepted this cycle.
- `req*_opcode`  in  7  RISC-V opcode.
- `req*_alu_op`  in  3  funct3.
- `req*_func7`  in  7  funct7.
- `req*_opA`  in  XLEN  operand A.
- `req*_opB`  in  XLEN  operand B.
- `alu_opcode`, `alu_alu_op`, `alu_func7`  out  7/3/7  to `alu`, registered.
- `alu_opA`, `alu_opB`  out  XLEN  to `alu`, registered.
- `alu_result`  in  XLEN  from `alu`.
- `alu_zero`, `alu_eq`, `alu_less`, `alu_err`  in  1  from `alu` flags.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_id`  out  1  requester the response belongs to.
- `rsp_result`  out  XLEN  captured result.
- `rsp_zero`, `rsp_eq`, `rsp_less`, `rsp_err`  out  1  captured flags.
- `busy`  out  1  high in EXEC.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE → EXEC on any accept; otherwise stay in IDLE.
- EXEC → RESP unconditionally. The `alu` evaluates the latched operation during EXEC. Result and flags are registered into `rsp_*` at the end of EXEC.
- In RESP, `rsp_valid`=1. RESP → EXEC if a request is accepted in the same cycle, else → IDLE.
- Accept is allowed only in IDLE or RESP. `reqN_ready` = (state≠EXEC) & `reqN_valid` & grant==N. `ready` may depend on `valid`; `valid` must not depend on `ready`.
- A requester holds `valid` and payload stable until `ready`.
- Arbitration: if only one port is valid, it wins. If both are valid, the port ≠ `last_grant` wins. `last_grant` updates on every accept.
- On accept, latch opcode/alu_op/func7/opA/opB into the `alu_*` registers and the winner index into `rsp_id`. The `alu_*` outputs hold their values between operations.
- `rsp_*` data hold their values until the next capture. They are meaningful only while `rsp_valid`=1.
- No response backpressure: the requester named by `rsp_id` must consume the response in the RESP cycle.
- `rsp_err` copies `alu_err`, so an invalid encoding still completes with `rsp_err`=1. `rsp_result` is unspecified for branch and invalid operations.

## Timing
- Reset values: state IDLE; `last_grant`=1, so port 0 wins the first contention.
- Reset values of outputs: `rsp_valid`, `rsp_id`, `busy`, `req*_ready`=0; all `rsp_*` and `alu_*` registers 0.
- Latency: accept at cycle T, EXEC at T+1, `rsp_valid` at T+2.
- Throughput: one operation per 2 cycles with back-to-back requests (accept in RESP).
- Simultaneous events:
  - In RESP, the response for the current op and the accept of the next op occur in the same cycle.
  - The response data belongs to the old op. The newly latched `alu_*` values appear at T+1.
- Starvation bound: with both ports continuously valid, grants strictly alternate. Each port waits at most 2 accepts.
- Reset mid-operation:
  - Any in-flight op is dropped; no `rsp_valid` occurs for it.
  - `rsp_valid`=0 in the cycle after reset.
  - No `ready` is asserted while `rst`=1.

## Test plan
- Single ADD: port 0 sends opcode 0110011, funct3 000, funct7 0000000, opA=5, opB=7 at T → `req0_ready`@T; `rsp_valid`@T+2 with `rsp_id`=0, `rsp_result`=12, `rsp_zero`=0, `rsp_err`=0.
- Contention: both ports valid from reset; port 0 sends SUB 9-9, port 1 sends XOR 0xF0^0x0F.
  - Grants go 0, 1, 0, 1.
  - Port 0 responses: `rsp_result`=0 with `rsp_zero`=1.
  - Port 1 responses: `rsp_result`=0xFF.
- Back-to-back: port 1 stays valid for 4 ops → accepts at T, T+2, T+4, T+6.
  - `rsp_valid` at T+2, T+4, T+6, T+8.
  - `busy` toggles 1/0 each cycle.
- Branch: port 1 sends opcode 1100011, funct3 000 (BEQ), opA=opB=0x1234 → `rsp_eq`=1, `rsp_less`=0, `rsp_err`=0, `rsp_id`=1.
- Invalid encoding: opcode 0000000 → response completes at T+2 with `rsp_err`=1.
- Reset in EXEC: accept at T, `rst`=1 at T+1:
  - No `rsp_valid` at T+2.
  - After release, state is IDLE and all outputs are 0.
  - The next contention grants port 0 first.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one combinational ALU between two requesters. Port 0 is the execute
// stage and port 1 is the branch/address unit. A round-robin arbiter picks the
// winner. The winning operation is latched into registers that drive the ALU.
// The ALU result and flags are captured at the end of the EXEC cycle. They are
// returned to the winner with a tagged, one-cycle response pulse.
//
// Ports (N = 0, 1):
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   reqN_valid / reqN_ready       request handshake; ready is combinational
//   reqN_opcode/alu_op/func7      RISC-V opcode, funct3, funct7 of the request
//   reqN_opA / reqN_opB           request operands
//   alu_opcode/alu_op/func7       registered control to the ALU
//   alu_opA / alu_opB             registered operands to the ALU
//   alu_result, alu_zero/eq/less/err  ALU outputs
//   rsp_valid, rsp_id             one-cycle response pulse and owning requester
//   rsp_result, rsp_zero/eq/less/err  captured ALU result and flags
//   busy                          high while the ALU evaluates (EXEC)
//
// Timing: accept at T, EXEC at T+1, rsp_valid at T+2. A new request may be
// accepted in the RESP cycle, which gives one operation every two cycles.
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [6:0]      req0_opcode,
    input  logic [2:0]      req0_alu_op,
    input  logic [6:0]      req0_func7,
    input  logic [XLEN-1:0] req0_opA,
    input  logic [XLEN-1:0] req0_opB,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [6:0]      req1_opcode,
    input  logic [2:0]      req1_alu_op,
    input  logic [6:0]      req1_func7,
    input  logic [XLEN-1:0] req1_opA,
    input  logic [XLEN-1:0] req1_opB,

    output logic [6:0]      alu_opcode,
    output logic [2:0]      alu_alu_op,
    output logic [6:0]      alu_func7,
    output logic [XLEN-1:0] alu_opA,
    output logic [XLEN-1:0] alu_opB,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            alu_eq,
    input  logic            alu_less,
    input  logic            alu_err,

    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_zero,
    output logic            rsp_eq,
    output logic            rsp_less,
    output logic            rsp_err,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;  // index of the port that won the most recent accept
    logic   grant;       // index of the port that would win this cycle
    logic   accept;

    // Round-robin choice. A lone valid port always wins. Under contention,
    // the port that did not win last time goes first, so grants alternate.
    // NOTE: every signal assigned in always_comb gets a default first;
    // otherwise an unassigned path infers a latch.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is gated by rst so that nothing is accepted while reset is held,
    // even though the state register only clears at the clock edge.
    assign req0_ready = ~rst && (state != EXEC) && req0_valid && (grant == 1'b0);
    assign req1_ready = ~rst && (state != EXEC) && req1_valid && (grant == 1'b1);
    assign accept     = req0_ready || req1_ready;

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;   // port 0 wins the first contention
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_eq     <= 1'b0;
            rsp_less   <= 1'b0;
            rsp_err    <= 1'b0;
            alu_opcode <= '0;
            alu_alu_op <= '0;
            alu_func7  <= '0;
            alu_opA    <= '0;
            alu_opB    <= '0;
        end else begin
            // Latch the winner. rsp_id changes at the end of RESP, so it
            // still names the old op during its response cycle.
            if (accept) begin
                last_grant <= grant;
                rsp_id     <= grant;
                if (grant) begin
                    alu_opcode <= req1_opcode;
                    alu_alu_op <= req1_alu_op;
                    alu_func7  <= req1_func7;
                    alu_opA    <= req1_opA;
                    alu_opB    <= req1_opB;
                end else begin
                    alu_opcode <= req0_opcode;
                    alu_alu_op <= req0_alu_op;
                    alu_func7  <= req0_func7;
                    alu_opA    <= req0_opA;
                    alu_opB    <= req0_opB;
                end
            end

            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (accept) begin
                        state <= EXEC;
                        busy  <= 1'b1;
                    end
                end

                // The ALU sees the latched operation for the whole cycle;
                // capture its outputs at the end of the cycle.
                EXEC: begin
                    state      <= RESP;
                    busy       <= 1'b0;
                    rsp_valid  <= 1'b1;
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_eq     <= alu_eq;
                    rsp_less   <= alu_less;
                    rsp_err    <= alu_err;
                end

                // The response is presented this cycle. A new accept overlaps it.
                RESP: begin
                    rsp_valid <= 1'b0;
                    if (accept) begin
                        state <= EXEC;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed bench for alu_share_arbiter. A small behavioural ALU stands in for
// the real alu. All expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;

    logic            clk;
    logic            rst;
    logic            req0_valid, req0_ready;
    logic [6:0]      req0_opcode;
    logic [2:0]      req0_alu_op;
    logic [6:0]      req0_func7;
    logic [XLEN-1:0] req0_opA, req0_opB;
    logic            req1_valid, req1_ready;
    logic [6:0]      req1_opcode;
    logic [2:0]      req1_alu_op;
    logic [6:0]      req1_func7;
    logic [XLEN-1:0] req1_opA, req1_opB;
    logic [6:0]      alu_opcode;
    logic [2:0]      alu_alu_op;
    logic [6:0]      alu_func7;
    logic [XLEN-1:0] alu_opA, alu_opB, alu_result;
    logic            alu_zero, alu_eq, alu_less, alu_err;
    logic            rsp_valid, rsp_id;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_zero, rsp_eq, rsp_less, rsp_err;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_share_arbiter #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_opcode(req0_opcode),
        .req0_alu_op(req0_alu_op),
        .req0_func7 (req0_func7),
        .req0_opA   (req0_opA),
        .req0_opB   (req0_opB),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_opcode(req1_opcode),
        .req1_alu_op(req1_alu_op),
        .req1_func7 (req1_func7),
        .req1_opA   (req1_opA),
        .req1_opB   (req1_opB),
        .alu_opcode (alu_opcode),
        .alu_alu_op (alu_alu_op),
        .alu_func7  (alu_func7),
        .alu_opA    (alu_opA),
        .alu_opB    (alu_opB),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_eq     (alu_eq),
        .alu_less   (alu_less),
        .alu_err    (alu_err),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_eq     (rsp_eq),
        .rsp_less   (rsp_less),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: the R-type subset and branch compares used below.
    always_comb begin
        alu_result = '0;
        alu_err    = 1'b0;
        case (alu_opcode)
            OP_R: begin
                case (alu_alu_op)
                    3'b000:  alu_result = (alu_func7 == F7_SUB) ? alu_opA - alu_opB
                                                                : alu_opA + alu_opB;
                    3'b100:  alu_result = alu_opA ^ alu_opB;
                    3'b110:  alu_result = alu_opA | alu_opB;
                    3'b111:  alu_result = alu_opA & alu_opB;
                    default: alu_err    = 1'b1;
                endcase
            end
            OP_BRANCH: alu_result = '0;
            default:   alu_err    = 1'b1;
        endcase
        alu_zero = (alu_result == '0);
        alu_eq   = (alu_opA == alu_opB);
        alu_less = ($signed(alu_opA) < $signed(alu_opB));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        req0_opcode = opc; req0_alu_op = f3; req0_func7 = f7;
        req0_opA = a; req0_opB = b; req0_valid = 1'b1;
    endtask

    task automatic drive1(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        req1_opcode = opc; req1_alu_op = f3; req1_func7 = f7;
        req1_opA = a; req1_opB = b; req1_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drive0('0, '0, '0, '0, '0); req0_valid = 1'b0;
        drive1('0, '0, '0, '0, '0); req1_valid = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        req0_valid = 1'b1; #1;
        check("ready_in_rst", req0_ready, 0);
        req0_valid = 1'b0;
        rst = 1'b0;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_alu_regs", {alu_opcode, alu_alu_op, alu_func7, alu_opA, alu_opB}, 0);
        check("rst_rsp_regs", {rsp_result, rsp_zero, rsp_eq, rsp_less, rsp_err}, 0);

        // ---------------- single ADD on port 0 ----------------
        drive0(OP_R, 3'b000, F7_ADD, 5, 7); #1;
        check("add_ready0", req0_ready, 1);
        check("add_ready1", req1_ready, 0);
        tick();                                   // T+1: EXEC
        req0_valid = 1'b0;
        check("add_busy", busy, 1);
        check("add_no_rsp_exec", rsp_valid, 0);
        check("add_alu_ops", {alu_opA, alu_opB}, {32'd5, 32'd7});
        tick();                                   // T+2: RESP
        check("add_rsp_valid", rsp_valid, 1);
        check("add_rsp_id", rsp_id, 0);
        check("add_result", rsp_result, 12);
        check("add_zero", rsp_zero, 0);
        check("add_err", rsp_err, 0);
        check("add_busy_resp", busy, 0);
        tick();
        check("add_rsp_pulse", rsp_valid, 0);

        // ---------------- contention from reset ----------------
        rst = 1'b1;
        drive0(OP_R, 3'b000, F7_SUB, 9, 9);
        drive1(OP_R, 3'b100, F7_ADD, 32'hF0, 32'h0F);
        #1;
        check("cont_ready_rst", {req0_ready, req1_ready}, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic exp_id;
            exp_id = (i % 2 == 1);
            #1;
            check($sformatf("cont_grant%0d", i), {req1_ready, req0_ready},
                  exp_id ? 2'b10 : 2'b01);
            tick();                               // EXEC
            check($sformatf("cont_exec_noready%0d", i), {req1_ready, req0_ready}, 0);
            check($sformatf("cont_busy%0d", i), busy, 1);
            tick();                               // RESP (next accept cycle)
            check($sformatf("cont_rsp_valid%0d", i), rsp_valid, 1);
            check($sformatf("cont_rsp_id%0d", i), rsp_id, exp_id);
            check($sformatf("cont_result%0d", i), rsp_result, exp_id ? 32'hFF : 32'h0);
            check($sformatf("cont_zero%0d", i), rsp_zero, exp_id ? 1'b0 : 1'b1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check("cont_idle", {busy, rsp_valid}, 0);

        // ---------------- back-to-back on port 1 ----------------
        for (int i = 0; i < 4; i++) begin
            drive1(OP_R, 3'b000, F7_ADD, i, 100);
            #1;
            check($sformatf("b2b_ready%0d", i), req1_ready, 1);
            check($sformatf("b2b_busy_lo%0d", i), busy, 0);
            if (i > 0) begin
                check($sformatf("b2b_rsp_valid%0d", i), rsp_valid, 1);
                check($sformatf("b2b_result%0d", i), rsp_result, 100 + i - 1);
            end
            tick();                               // EXEC
            check($sformatf("b2b_busy_hi%0d", i), busy, 1);
            check($sformatf("b2b_no_rsp%0d", i), rsp_valid, 0);
            tick();                               // RESP
        end
        req1_valid = 1'b0;
        check("b2b_last_valid", rsp_valid, 1);
        check("b2b_last_result", rsp_result, 103);
        check("b2b_last_id", rsp_id, 1);
        tick();
        check("b2b_idle", {busy, rsp_valid}, 0);

        // ---------------- branch BEQ on port 1 ----------------
        drive1(OP_BRANCH, 3'b000, F7_ADD, 32'h1234, 32'h1234); #1;
        check("beq_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        check("beq_rsp_valid", rsp_valid, 1);
        check("beq_flags", {rsp_eq, rsp_less, rsp_err}, 3'b100);
        check("beq_id", rsp_id, 1);
        tick();

        // ---------------- invalid encoding on port 0 ----------------
        drive0(7'b0000000, 3'b000, F7_ADD, 3, 4); #1;
        check("inv_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        tick();
        check("inv_rsp_valid", rsp_valid, 1);
        check("inv_err", rsp_err, 1);
        check("inv_id", rsp_id, 0);
        tick();

        // ---------------- reset during EXEC ----------------
        drive0(OP_R, 3'b000, F7_ADD, 1, 2); #1;
        check("rexec_ready", req0_ready, 1);
        tick();                                   // T+1: EXEC
        req0_valid = 1'b0;
        rst = 1'b1;
        check("rexec_busy", busy, 1);
        tick();                                   // T+2
        check("rexec_no_rsp", rsp_valid, 0);
        check("rexec_busy_clr", busy, 0);
        req1_valid = 1'b1; #1;
        check("rexec_ready_in_rst", req1_ready, 0);
        req1_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("rexec_no_rsp_after", rsp_valid, 0);
        check("rexec_alu_regs", {alu_opcode, alu_alu_op, alu_func7, alu_opA, alu_opB}, 0);
        check("rexec_rsp_regs", {rsp_id, rsp_result, rsp_zero, rsp_eq, rsp_less, rsp_err}, 0);
        drive0(OP_R, 3'b000, F7_ADD, 2, 3);
        drive1(OP_R, 3'b000, F7_ADD, 4, 5);
        #1;
        check("rexec_first_grant", {req1_ready, req0_ready}, 2'b01);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check("rexec_rsp_id", rsp_id, 0);
        check("rexec_rsp_result", rsp_result, 5);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
